// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Brief    : Shared constants and types for the multi-channel PWM generator.
// Revision : 1.0
// ============================================================================
package pwm_pkg;

    localparam logic PWM_MODE_EDGE   = 1'b0;
    localparam logic PWM_MODE_CENTER = 1'b1;

    localparam int PWM_NUM_CH_DEF  = 4;
    localparam int PWM_RES_DEF     = 32;
    localparam int PWM_PRESC_W_DEF = 16;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

endpackage
`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : pwm_prescaler
// Brief    : Timebase tick generator, one tick every prescale_i+1 clocks.
// Revision : 1.0
// ============================================================================
module pwm_prescaler #(
    parameter int PRESC_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic [PRESC_W-1:0] prescale_i,
    output logic               tick_o
);

    logic [PRESC_W-1:0] presc_cnt_q;
    logic [PRESC_W-1:0] presc_cnt_d;

    assign tick_o = enable_i && (presc_cnt_q == prescale_i);

    // A prescale value lowered below the running count wraps silently, no tick.
    always_comb begin
        presc_cnt_d = presc_cnt_q + 1'b1;
        if (!enable_i || (presc_cnt_q >= prescale_i)) begin
            presc_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_multi_channel.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi_channel
// Brief    : Shared-timebase PWM with NUM_CH compare channels, edge/center
//            counting and double-buffered mode/period/duty.
// Revision : 1.0
// ============================================================================
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int NUM_CH  = PWM_NUM_CH_DEF,
    parameter int RES     = PWM_RES_DEF,
    parameter int PRESC_W = PWM_PRESC_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  mode_i,
    input  logic [RES-1:0]        period_i,
    input  logic [PRESC_W-1:0]    prescale_i,
    input  logic [NUM_CH*RES-1:0] duty_i,
    input  logic [NUM_CH-1:0]     polarity_i,
    input  logic                  load_i,
    output logic                  update_pending_o,
    output logic [NUM_CH-1:0]     pwm_o,
    output logic                  period_end_o,
    output logic [RES-1:0]        counter_o
);

    logic                  w_tick;
    logic                  w_boundary;
    logic                  w_apply;
    logic [NUM_CH-1:0]     w_raw;

    logic [RES-1:0]        cnt_q, cnt_d;
    pwm_dir_e              dir_q, dir_d;
    logic                  mode_q, sh_mode_q;
    logic [RES-1:0]        period_q, sh_period_q;
    logic [NUM_CH*RES-1:0] duty_q, sh_duty_q;
    logic                  pending_q, pending_d;
    logic [NUM_CH-1:0]     pwm_q;
    logic                  period_end_q;

    pwm_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .enable_i   (enable_i),
        .prescale_i (prescale_i),
        .tick_o     (w_tick)
    );

    always_comb begin
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        w_boundary = 1'b0;
        if (!enable_i) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end else if (w_tick) begin
            if (mode_q == PWM_MODE_EDGE) begin
                dir_d = DIR_UP;
                if (cnt_q >= period_q) begin
                    cnt_d      = '0;
                    w_boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (dir_q == DIR_UP) begin
                if (period_q == '0) begin
                    cnt_d      = '0;
                    w_boundary = 1'b1;
                end else if (cnt_q >= period_q) begin
                    // With period 1 the turnaround is itself the 1->0 step.
                    if (cnt_q <= 1) begin
                        cnt_d      = '0;
                        w_boundary = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                        dir_d = DIR_DOWN;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q <= 1) begin
                    cnt_d      = '0;
                    dir_d      = DIR_UP;
                    w_boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
    end

    // A load on the boundary tick is applied only at the following boundary.
    assign w_apply = pending_q && (w_boundary || !enable_i);

    always_comb begin
        pending_d = pending_q;
        if (w_apply) pending_d = 1'b0;
        if (load_i)  pending_d = 1'b1;
    end

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            assign w_raw[c] = (cnt_q < duty_q[c*RES +: RES]);
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            dir_q        <= DIR_UP;
            mode_q       <= PWM_MODE_EDGE;
            period_q     <= '0;
            duty_q       <= '0;
            sh_mode_q    <= PWM_MODE_EDGE;
            sh_period_q  <= '0;
            sh_duty_q    <= '0;
            pending_q    <= 1'b0;
            pwm_q        <= '0;
            period_end_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            pending_q    <= pending_d;
            period_end_q <= w_boundary;
            pwm_q        <= enable_i ? (w_raw ^ polarity_i) : polarity_i;
            if (w_apply) begin
                mode_q   <= sh_mode_q;
                period_q <= sh_period_q;
                duty_q   <= sh_duty_q;
            end
            if (load_i) begin
                sh_mode_q   <= mode_i;
                sh_period_q <= period_i;
                sh_duty_q   <= duty_i;
            end
        end
    end

    assign update_pending_o = pending_q;
    assign pwm_o            = pwm_q;
    assign period_end_o     = period_end_q;
    assign counter_o        = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_channel.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi_channel
// Brief    : Directed self-checking bench for pwm_multi_channel (RES=8).
// Revision : 1.0
// ============================================================================
module tb_pwm_multi_channel;

    localparam int NUM_CH  = 4;
    localparam int RES     = 8;
    localparam int PRESC_W = 4;

    logic                  clk = 1'b0;
    logic                  rst_i;
    logic                  enable_i;
    logic                  mode_i;
    logic [RES-1:0]        period_i;
    logic [PRESC_W-1:0]    prescale_i;
    logic [NUM_CH*RES-1:0] duty_i;
    logic [NUM_CH-1:0]     polarity_i;
    logic                  load_i;
    logic                  update_pending_o;
    logic [NUM_CH-1:0]     pwm_o;
    logic                  period_end_o;
    logic [RES-1:0]        counter_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwm_multi_channel #(
        .NUM_CH  (NUM_CH),
        .RES     (RES),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .enable_i         (enable_i),
        .mode_i           (mode_i),
        .period_i         (period_i),
        .prescale_i       (prescale_i),
        .duty_i           (duty_i),
        .polarity_i       (polarity_i),
        .load_i           (load_i),
        .update_pending_o (update_pending_o),
        .pwm_o            (pwm_o),
        .period_end_o     (period_end_o),
        .counter_o        (counter_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Center mode, period 4, prescale 1: counter after clock k of the run.
    function automatic int cen(input int k);
        int t;
        t = ((k + 1) >>> 1) % 8;
        return (t <= 4) ? t : 8 - t;
    endfunction

    initial begin
        logic [3:0] e;
        rst_i = 1'b1; enable_i = 1'b0; mode_i = 1'b0; period_i = '0;
        prescale_i = '0; duty_i = '0; polarity_i = '0; load_i = 1'b0;
        step(); step();
        check("rst_pwm", pwm_o, 0);
        check("rst_pend", update_pending_o, 0);
        check("rst_pe", period_end_o, 0);
        check("rst_cnt", counter_o, 0);

        // Edge mode: period 9, duties 3/0/10/5
        rst_i = 1'b0; period_i = 8'd9; duty_i = {8'd5, 8'd10, 8'd0, 8'd3}; load_i = 1'b1;
        step();
        check("load_pend", update_pending_o, 1);
        load_i = 1'b0;
        step();
        check("dis_apply_pend", update_pending_o, 0);
        enable_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            e = {4'((k % 10) < 5), 1'b1, 1'b0, 1'((k % 10) < 3)};
            check("edge_cnt", counter_o, (k + 1) % 10);
            check("edge_pwm", pwm_o, e);
            check("edge_pe", period_end_o, ((k + 1) % 10) == 0);
        end

        // Shadow update of duty0 to 7 loaded at cnt=2
        step(); step();
        check("sh_cnt2", counter_o, 2);
        duty_i = {8'd5, 8'd10, 8'd0, 8'd7}; load_i = 1'b1;
        step();
        check("sh_pend", update_pending_o, 1);
        check("sh_cnt3", counter_o, 3);
        load_i = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            check("sh_pend_hold", update_pending_o, k < 6);
            check("sh_old_pwm0", pwm_o[0], 0);
            check("sh_cnt", counter_o, (k < 6) ? 4 + k : 0);
            check("sh_pe", period_end_o, k == 6);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            check("sh_new_pwm0", pwm_o[0], k < 7);
            check("sh_new_cnt", counter_o, (k + 1) % 10);
            check("sh_new_pe", period_end_o, k == 9);
        end

        // Load coincident with boundary while nothing pending
        for (int k = 0; k < 9; k++) step();
        check("sim_cnt9", counter_o, 9);
        duty_i = {8'd5, 8'd10, 8'd0, 8'd2}; load_i = 1'b1;
        step();
        check("sim_pe", period_end_o, 1);
        check("sim_cnt0", counter_o, 0);
        check("sim_pend", update_pending_o, 1);
        load_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("sim_keep_pwm0", pwm_o[0], k < 7);
            check("sim_pend_hold", update_pending_o, k < 9);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            check("sim_new_pwm0", pwm_o[0], k < 2);
        end
        check("sim_end_cnt", counter_o, 0);

        // Polarity and disable
        enable_i = 1'b0; polarity_i = 4'b0001;
        step();
        check("dis_pwm", pwm_o, 4'b0001);
        check("dis_cnt", counter_o, 0);
        check("dis_pe", period_end_o, 0);
        enable_i = 1'b1;
        step();
        check("pol_pwm_a", pwm_o, 4'b1100);
        check("pol_cnt1", counter_o, 1);
        step();
        check("pol_pwm_b", pwm_o, 4'b1100);
        step();
        check("pol_pwm_c", pwm_o, 4'b1101);
        check("pol_cnt3", counter_o, 3);
        polarity_i = 4'b0000;
        step();
        check("pol_toggle", pwm_o, 4'b1100);
        check("pol_cnt4", counter_o, 4);

        // Reset mid-cycle with a pending shadow
        duty_i = {8'd5, 8'd10, 8'd0, 8'd4}; load_i = 1'b1;
        step();
        check("mr_cnt5", counter_o, 5);
        check("mr_pend", update_pending_o, 1);
        load_i = 1'b0; rst_i = 1'b1;
        step();
        check("mr_pwm", pwm_o, 0);
        check("mr_cnt", counter_o, 0);
        check("mr_pend0", update_pending_o, 0);
        check("mr_pe", period_end_o, 0);
        rst_i = 1'b0;
        step();
        check("mr_p0_pe", period_end_o, 1);
        check("mr_p0_cnt", counter_o, 0);
        check("mr_p0_pwm", pwm_o, 0);
        check("mr_p0_pend", update_pending_o, 0);

        // Center mode: period 4, duty0 2, prescale 1
        enable_i = 1'b0; mode_i = 1'b1; period_i = 8'd4;
        duty_i = {8'd0, 8'd0, 8'd0, 8'd2}; prescale_i = 4'd1; load_i = 1'b1;
        step();
        check("cen_pend", update_pending_o, 1);
        load_i = 1'b0;
        step();
        check("cen_applied", update_pending_o, 0);
        enable_i = 1'b1;
        for (int k = 0; k < 32; k++) begin
            step();
            check("cen_cnt", counter_o, cen(k));
            check("cen_pwm0", pwm_o[0], cen(k - 1) < 2);
            check("cen_pe", period_end_o, (k == 15) || (k == 31));
        end

        // Prescale lowered below the running prescaler count
        step();
        check("pl_cnt_a", counter_o, 0);
        prescale_i = 4'd0;
        step();
        check("pl_wrap_cnt", counter_o, 0);
        check("pl_wrap_pe", period_end_o, 0);
        step();
        check("pl_tick_cnt", counter_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
